// File: rtl/sprite_mover.sv
// Sprite mover: clears the screen, draws a ROM sprite at its home position,
// then moves it by STEP pixels per command (erase old, redraw new), clamped
// to the screen. Pixel writes go out on x_out/y_out/colour_out/plot.
module sprite_mover #(
  parameter int          SPRITE_W    = 11,
  parameter int          SPRITE_H    = 10,
  parameter int          STEP        = 5,
  parameter int          X_START     = 73,
  parameter int          Y_START     = 105,
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter logic [2:0]  KEY_COLOUR  = 3'b111,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       move_up,
  input  logic       move_down,
  output logic [9:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic       ready,
  output logic       at_edge
);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, READY, ERASE, DRAW_MOVE, HOLD} state_t;

  localparam logic signed [8:0] STEP_S = 9'(STEP);
  localparam logic signed [8:0] X_MAX  = 9'(SCREEN_W - SPRITE_W);
  localparam logic signed [8:0] Y_MAX  = 9'(SCREEN_H - SPRITE_H);

  state_t state, nextState;

  // Scan position; drain is the extra cycle that lets the last pixel
  // (delayed one cycle behind its ROM address) leave before the state changes.
  logic [7:0] col;
  logic [6:0] row;
  logic       drain;
  logic [7:0] holdCnt;
  logic [7:0] tgtX;
  logic [6:0] tgtY;
  logic       outPlot, outRom;

  logic              scanning, spriteScan, lastPix, cmd, blocked;
  logic [7:0]        lastColV;
  logic [6:0]        lastRowV;
  logic signed [8:0] dx, dy, candX, candY, clX, clY;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Scan limits, ROM address, command decode/clamp and next state.
  always_comb begin
    scanning   = state inside {CLEAR, DRAW, ERASE, DRAW_MOVE};
    spriteScan = state inside {DRAW, ERASE, DRAW_MOVE};
    lastColV   = (state == CLEAR) ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
    lastRowV   = (state == CLEAR) ? 7'(SCREEN_H - 1) : 7'(SPRITE_H - 1);
    lastPix    = (col == lastColV) && (row == lastRowV);
    rom_addr   = (spriteScan && !drain) ? 10'(int'(row) * SPRITE_W + int'(col)) : 10'd0;
    ready      = (state == READY);

    // Opposing pairs cancel; horizontal beats vertical, left beats right.
    dx = 9'sd0;
    dy = 9'sd0;
    if      (move_left  && !move_right) dx = -STEP_S;
    else if (move_right && !move_left)  dx = STEP_S;
    else if (move_up    && !move_down)  dy = -STEP_S;
    else if (move_down  && !move_up)    dy = STEP_S;
    cmd     = (dx != 9'sd0) || (dy != 9'sd0);
    candX   = $signed({1'b0, pos_x}) + dx;
    candY   = $signed({2'b0, pos_y}) + dy;
    clX     = (candX < 9'sd0) ? 9'sd0 : (candX > X_MAX) ? X_MAX : candX;
    clY     = (candY < 9'sd0) ? 9'sd0 : (candY > Y_MAX) ? Y_MAX : candY;
    blocked = (clX == $signed({1'b0, pos_x})) && (clY == $signed({2'b0, pos_y}));

    nextState = state;
    case (state)
      IDLE:      if (start) nextState = CLEAR;
      CLEAR:     if (drain) nextState = DRAW;
      DRAW:      if (drain) nextState = READY;
      READY:     if (cmd && !blocked) nextState = ERASE;
      ERASE:     if (drain) nextState = DRAW_MOVE;
      DRAW_MOVE: if (drain) nextState = HOLD;
      HOLD:      if (holdCnt == 8'(HOLD_CYCLES - 1)) nextState = READY;
      default:   nextState = IDLE;
    endcase
  end

  // Scan counters, pixel output registers, position and hold timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col     <= '0;
      row     <= '0;
      drain   <= 1'b0;
      holdCnt <= '0;
      tgtX    <= 8'(X_START);
      tgtY    <= 7'(Y_START);
      pos_x   <= 8'(X_START);
      pos_y   <= 7'(Y_START);
      x_out   <= '0;
      y_out   <= '0;
      outPlot <= 1'b0;
      outRom  <= 1'b0;
      at_edge <= 1'b0;
    end else begin
      outPlot <= 1'b0;
      outRom  <= 1'b0;
      at_edge <= 1'b0;
      if (scanning && !drain) begin
        outPlot <= 1'b1;
        outRom  <= (state == DRAW) || (state == DRAW_MOVE);
        x_out   <= (state == CLEAR) ? col : pos_x + col;
        y_out   <= (state == CLEAR) ? row : pos_y + row;
        if (lastPix) begin
          drain <= 1'b1;
          col   <= '0;
          row   <= '0;
        end else if (col == lastColV) begin
          col <= '0;
          row <= row + 7'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
      if (scanning && drain) drain <= 1'b0;
      if (state == READY && cmd) begin
        if (blocked) at_edge <= 1'b1;
        else begin
          tgtX <= clX[7:0];
          tgtY <= clY[6:0];
        end
      end
      if (state == ERASE && drain) begin
        pos_x <= tgtX;
        pos_y <= tgtY;
      end
      holdCnt <= (state == HOLD) ? holdCnt + 8'd1 : 8'd0;
    end
  end

  // ROM colour arrives in the same cycle as the registered coordinates;
  // transparent sprite pixels suppress the write, erase/clear never do.
  assign plot       = outPlot && !(outRom && rom_data == KEY_COLOUR);
  assign colour_out = outRom ? rom_data : 3'd0;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: startup clear/draw, table of move commands with
// hand-derived positions, random commands against a pixel-list model, and
// reset during an erase.
module tb_sprite_mover;
  localparam int SW = 160, SH = 120, W = 11, H = 10, STEP = 5, HOLD = 4;
  localparam int X0 = 73, Y0 = 105, KEY = 7, N = W * H;

  logic clk = 0, reset = 0, start = 0;
  logic move_left = 0, move_right = 0, move_up = 0, move_down = 0;
  logic [9:0] rom_addr;
  logic [2:0] rom_data = 0, colour_out;
  logic [7:0] x_out, pos_x;
  logic [6:0] y_out, pos_y;
  logic plot, ready, at_edge;

  sprite_mover dut (
    .clk(clk), .reset(reset), .start(start),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .pos_x(pos_x), .pos_y(pos_y), .ready(ready), .at_edge(at_edge)
  );

  always #5 clk = ~clk;

  logic [2:0] rom [0:1023];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int x; int y; int c; int t; } pix_t;
  pix_t plotQ[$];
  pix_t expQ[$];
  always @(negedge clk) if (plot === 1'b1) plotQ.push_back('{int'(x_out), int'(y_out), int'(colour_out), cyc});

  int nCmp = 0, nFail = 0;
  int mX = X0, mY = Y0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Expected pixel writes for one sprite pass at (px,py).
  function automatic void addSprite(int px, int py, bit erase);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int col = erase ? 0 : int'(rom[r * W + c]);
        if (erase || col != KEY) expQ.push_back('{px + c, py + r, col, 0});
      end
  endfunction

  task automatic cmpPlots(input string name, input int base);
    int bad = 0;
    check({name, ".nplot"}, plotQ.size() - base, expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      if (base + i >= plotQ.size() || plotQ[base + i].x != expQ[i].x ||
          plotQ[base + i].y != expQ[i].y || plotQ[base + i].c != expQ[i].c) bad++;
    check({name, ".pix"}, bad, 0);
  endtask

  task automatic waitReady(input int budget, output int rc, output bit ok);
    ok = 0; rc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin ok = 1; rc = cyc; break; end
    end
  endtask

  // Apply one command for one cycle from READY and check the outcome.
  task automatic doMove(input bit l, input bit r, input bit u, input bit d,
                        input string name, output bit edgeSeen);
    int dx = 0, dy = 0, tx, ty, c0, rc;
    bit isCmd, moves, ok;
    if (l && !r) dx = -STEP; else if (r && !l) dx = STEP;
    else if (u && !d) dy = -STEP; else if (d && !u) dy = STEP;
    tx = clampi(mX + dx, 0, SW - W);
    ty = clampi(mY + dy, 0, SH - H);
    isCmd = (dx != 0) || (dy != 0);
    moves = isCmd && (tx != mX || ty != mY);
    plotQ.delete(); expQ.delete();
    c0 = cyc;
    move_left = l; move_right = r; move_up = u; move_down = d;
    @(negedge clk);
    move_left = 0; move_right = 0; move_up = 0; move_down = 0;
    edgeSeen = at_edge;
    check({name, ".at_edge"}, at_edge, isCmd && !moves);
    if (moves) begin
      addSprite(mX, mY, 1);
      addSprite(tx, ty, 0);
      waitReady(600, rc, ok);
      check({name, ".ready_seen"}, ok, 1);
      check({name, ".move_cycles"}, rc - (c0 + 1), 2 * (N + 1) + HOLD);
      mX = tx; mY = ty;
    end else begin
      @(negedge clk);
      check({name, ".at_edge_pulse"}, at_edge, 0);
      repeat (2) @(negedge clk);
      check({name, ".stay_ready"}, ready, 1);
    end
    check({name, ".pos_x"}, pos_x, mX);
    check({name, ".pos_y"}, pos_y, mY);
    cmpPlots(name, 0);
  endtask

  typedef struct { bit l, r, u, d; int reps; int ex, ey; bit eedge; } vec_t;
  vec_t tbl[14];

  initial begin
    int rc, bad, base;
    bit ok, e;
    tbl[0]  = '{1, 1, 1, 0, 1,  73, 100, 0};  // L+R cancel, up wins
    tbl[1]  = '{0, 1, 0, 0, 1,  78, 100, 0};
    tbl[2]  = '{0, 0, 0, 1, 2,  78, 110, 0};
    tbl[3]  = '{0, 0, 0, 1, 1,  78, 110, 1};  // bottom edge
    tbl[4]  = '{0, 0, 1, 1, 1,  78, 110, 0};  // no net command
    tbl[5]  = '{1, 0, 1, 0, 1,  73, 110, 0};  // left beats up
    tbl[6]  = '{1, 0, 0, 0, 14,  3, 110, 0};
    tbl[7]  = '{1, 0, 0, 0, 1,   0, 110, 0};  // 3 clamps to 0
    tbl[8]  = '{1, 0, 0, 0, 1,   0, 110, 1};
    tbl[9]  = '{0, 1, 0, 0, 30, 149, 110, 0}; // last step clamps to 149
    tbl[10] = '{0, 1, 0, 0, 1, 149, 110, 1};
    tbl[11] = '{0, 0, 1, 0, 22, 149, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 149,   0, 1};
    tbl[13] = '{1, 1, 0, 0, 1, 149,   0, 0};

    for (int i = 0; i < 1024; i++) rom[i] = 3'($urandom_range(0, 7));
    rom[0] = 3'(KEY);
    rom[N - 1] = 3'd3;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.plot", plot, 0);
    check("rst.x_out", x_out, 0);
    check("rst.y_out", y_out, 0);
    check("rst.colour", colour_out, 0);
    check("rst.rom_addr", rom_addr, 0);
    check("rst.at_edge", at_edge, 0);
    check("rst.ready", ready, 0);
    check("rst.pos_x", pos_x, X0);
    check("rst.pos_y", pos_y, Y0);
    reset = 1;
    repeat (3) @(negedge clk);
    check("idle.no_plot", plotQ.size(), 0);

    // Startup: clear then home draw.
    plotQ.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    waitReady(25000, rc, ok);
    check("start.ready_seen", ok, 1);
    check("start.nplot_min", plotQ.size() >= SW * SH, 1);
    if (plotQ.size() >= SW * SH) begin
      bad = 0;
      for (int i = 0; i < SW * SH; i++)
        if (plotQ[i].x != i % SW || plotQ[i].y != i / SW || plotQ[i].c != 0 ||
            plotQ[i].t != plotQ[0].t + i) bad++;
      check("clear.raster", bad, 0);
      check("draw.cycles", rc - plotQ[SW * SH - 1].t - 1, N + 1);
      expQ.delete();
      addSprite(X0, Y0, 0);
      cmpPlots("draw", SW * SH);
      bad = 0;
      for (int i = SW * SH; i < plotQ.size(); i++)
        if (plotQ[i].x == X0 && plotQ[i].y == Y0) bad++;
      check("draw.key_skipped", bad, 0);
    end
    check("start.pos_x", pos_x, X0);
    check("start.pos_y", pos_y, Y0);

    // Table of commands with hand-derived positions.
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        doMove(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, $sformatf("tbl%0d", i), e);
      check($sformatf("tbl%0d.x", i), pos_x, tbl[i].ex);
      check($sformatf("tbl%0d.y", i), pos_y, tbl[i].ey);
      check($sformatf("tbl%0d.edge", i), e, tbl[i].eedge);
    end

    // Random commands against the model.
    for (int i = 0; i < 25; i++) begin
      int b = $urandom_range(0, 15);
      doMove(b[0], b[1], b[2], b[3], $sformatf("rnd%0d", i), e);
    end

    // Reset in the middle of an erase.
    if (mX == 0) move_right = 1; else move_left = 1;
    @(negedge clk);
    move_left = 0; move_right = 0;
    repeat (20) @(negedge clk);
    check("mid.erasing", plot, 1);
    reset = 0;
    @(negedge clk);
    check("mid.rst_plot", plot, 0);
    check("mid.rst_pos_x", pos_x, X0);
    check("mid.rst_pos_y", pos_y, Y0);
    check("mid.rst_ready", ready, 0);
    reset = 1;
    plotQ.delete();
    base = 0;
    repeat (5) @(negedge clk) if (ready === 1'b1) base++;
    check("mid.idle_no_plot", plotQ.size(), 0);
    check("mid.idle_not_ready", base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter SPRITE_W, default 11, sprite width in pixels (1..32).
REQ-002 SHALL have parameter SPRITE_H, default 10, sprite height in pixels (1..32).
REQ-003 SHALL have parameter STEP, default 5, pixels moved per accepted command (1..15).
REQ-004 SHALL have parameter X_START, default 73, sprite home x (top-left).
REQ-005 SHALL have parameter Y_START, default 105, sprite home y (top-left).
REQ-006 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-007 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-008 SHALL have parameter KEY_COLOUR, default 3'b111, transparent colour; a sprite pixel of this colour is never plotted.
REQ-009 SHALL have parameter HOLD_CYCLES, default 4, cycles between a completed move and the next accepted command (>=1).
REQ-010 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-011 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-012 SHALL have port start, input, 1, begins screen clear and home draw from IDLE.
REQ-013 SHALL have ports move_left, move_right, move_up, move_down, input, 1 each, level-sampled move commands.
REQ-014 SHALL have port rom_addr, output, 10, sprite ROM address = row*SPRITE_W+col.
REQ-015 SHALL have port rom_data, input, 3, sprite ROM colour, valid exactly 1 cycle after rom_addr.
REQ-016 SHALL have ports x_out (8), y_out (7), colour_out (3), plot (1), outputs, VGA pixel write; a pixel is written when plot=1.
REQ-017 SHALL have ports pos_x (8), pos_y (7), outputs, current sprite top-left.
REQ-018 SHALL have port ready, output, 1, high only in READY state.
REQ-019 SHALL have port at_edge, output, 1, one-cycle pulse when a command is rejected by clamping.

Function
REQ-020 SHALL implement states IDLE, CLEAR, DRAW, READY, ERASE, DRAW_MOVE, HOLD.
REQ-021 SHALL go IDLE->CLEAR when start=1; CLEAR->DRAW after the last pixel; DRAW->READY and DRAW_MOVE->HOLD after the last sprite pixel; HOLD->READY after HOLD_CYCLES cycles.
REQ-022 CLEAR SHALL plot every pixel (0,0)..(SCREEN_W-1,SCREEN_H-1) in raster order, colour 0, one per cycle, exactly SCREEN_W*SCREEN_H plot cycles with no gaps.
REQ-023 DRAW and DRAW_MOVE SHALL scan the sprite in raster order at (pos_x+col, pos_y+row), one address per cycle; plot/x_out/y_out/colour_out SHALL be registered one cycle after rom_addr so that they align with rom_data.
REQ-024 A sprite pixel with rom_data==KEY_COLOUR SHALL have plot=0 for its cycle; total scan time SHALL remain SPRITE_W*SPRITE_H+1 cycles.
REQ-025 ERASE SHALL plot colour 0 over all SPRITE_W*SPRITE_H pixels at the old position, ignoring transparency.
REQ-026 In READY, command priority SHALL be left > right > up > down; left and right together or up and down together SHALL cancel each other, and the remaining pair SHALL be resolved by priority.
REQ-027 The target position SHALL be clamped: x in [0, SCREEN_W-SPRITE_W], y in [0, SCREEN_H-SPRITE_H]; arithmetic SHALL use 9-bit signed intermediates so that no wrap-around can occur.
REQ-028 If the clamped target equals the current position, the block SHALL pulse at_edge for 1 cycle, stay in READY, and produce no plots.
REQ-029 Otherwise the block SHALL go to ERASE (old position), then update pos_x/pos_y in one cycle, then go to DRAW_MOVE (new position).
REQ-030 Commands SHALL be ignored outside READY; commands held high SHALL repeat only after HOLD.
REQ-031 plot SHALL be 0 in IDLE, READY and HOLD.

Reset
REQ-032 On reset=0 the block SHALL enter IDLE on the next edge from any state, including mid-scan.
REQ-033 Reset values SHALL be: plot=0, x_out=0, y_out=0, colour_out=0, rom_addr=0, at_edge=0, ready=0, pos_x=X_START, pos_y=Y_START, all counters 0.

Verification
REQ-034 Reset, then start for 1 cycle -> exactly 19200 black plots, then 110 sprite cycles at x 73..83, y 105..114, then ready=1 with pos=(73,105).
REQ-035 ROM returning KEY_COLOUR at address 0 -> pixel (73,105) not plotted, every other sprite pixel plotted with its ROM colour.
REQ-036 READY with move_right=1 -> 110 black plots at old position, then pos_x=78, 110-cycle draw over x 78..88, HOLD for 4 cycles, then ready=1.
REQ-037 pos_x=3 with move_left -> pos_x=0; further move_left -> at_edge pulse, zero plots; pos_x=149 with move_right -> at_edge.
REQ-038 move_left and move_right asserted together with move_up -> vertical move only, pos_y=100.
REQ-039 Reset asserted mid-ERASE -> next cycle IDLE, plot=0, pos=(73,105).
